seg7_to_bcd_capture: RTL and testbench
======================================

SEG7_TO_BCD_CAPTURE -- requirements
Module: seg7_to_bcd_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, the number of multiplexed display digits monitored (range 1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 3, the consecutive identical samples required before capture (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port n7Segs  input  7  active-low segment pattern {g,f,e,d,c,b,a}, bit 0 = segment a.
REQ-006 SHALL have port digitSel  input  NUM_DIGITS  one-hot active-high digit strobe; bit i means n7Segs belongs to digit i.
REQ-007 SHALL have port BCD  output  4*NUM_DIGITS  captured digit codes; digit i in bits [4i+3:4i].
REQ-008 SHALL have port valid  output  NUM_DIGITS  bit i high when digit i holds a decoded numeral 0..9.
REQ-009 SHALL have port update  output  1  one-cycle pulse, the cycle after any capture.
REQ-010 SHALL have port errFlag  output  1  sticky flag: illegal pattern captured since reset.

Function
REQ-011 SHALL register {digitSel, n7Segs} every cycle into a sample register and compare the current inputs against it.
REQ-012 SHALL implement FSM states EMPTY, COUNT, HELD.
- EMPTY: after reset; the next edge loads the sample, sets run=1, moves to COUNT (or captures directly if STABLE_CYCLES=1).
- COUNT: equal inputs -> run+1; unequal -> reload sample, run=1, stay in COUNT.
- When run reaches STABLE_CYCLES: capture on that same edge, move to HELD.
- HELD: equal inputs -> no further capture; unequal -> reload sample, run=1, go to COUNT.
REQ-013 SHALL capture on the edge at which the inputs have been identical on STABLE_CYCLES consecutive edges; BCD/valid/errFlag visible after that edge; update high for exactly the following cycle.
REQ-014 SHALL skip capture and hold all outputs when digitSel is not one-hot (all zero or multiple bits); FSM still tracks stability but no state changes.
REQ-015 SHALL decode (active-low) 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9; BCD digit i <= code, valid[i] <= 1.
REQ-016 SHALL treat 1111111 (blank) as legal: BCD digit i <= 4'b1111, valid[i] <= 0, errFlag unchanged, update pulses.
REQ-017 SHALL treat every other pattern as illegal: digit i and valid[i] retained, errFlag <= 1, update pulses.
REQ-018 SHALL saturate run at STABLE_CYCLES; run width 4 bits.
REQ-019 SHALL update only the selected digit per capture; other digits untouched.

Reset
REQ-020 SHALL on rst high at an edge set BCD to all 4'b1111, valid=0, update=0, errFlag=0, run=0, sample=0, FSM=EMPTY, overriding any in-progress count or capture.
REQ-021 SHALL require no capture on the first edge after rst deasserts until STABLE_CYCLES samples have been seen afresh.

Configuration
REQ-022 SHALL, when macro SEG7_ERR_COUNT_EN is defined, add output errCount (8 bits) counting illegal captures, saturating at 255, cleared only by rst.
REQ-023 SHALL, when SEG7_ERR_COUNT_EN is undefined, omit errCount entirely; all other behaviour identical.

Verification
REQ-024 SHALL cover: rst, digitSel=0001, n7Segs=0110000 held 3 cycles -> after 3rd edge BCD[3:0]=3, valid=0001, update pulse 1 cycle; held 10 more cycles -> no further update.
REQ-025 SHALL cover: digitSel=0010, pattern 0010010 held 2 cycles then 0000010 held 3 -> BCD[7:4]=6 only, one update, digit 0 unchanged.
REQ-026 SHALL cover: digitSel=0100, pattern 1010101 held 3 cycles -> errFlag=1, BCD[11:8]=F, valid[2]=0, update pulse; errCount=1 when SEG7_ERR_COUNT_EN defined.
REQ-027 SHALL cover: digitSel=1100 with valid pattern 3 cycles -> no update, outputs unchanged; then digitSel=1000, 1111111 -> BCD[15:12]=F, valid[3]=0, update pulse.
REQ-028 SHALL cover: rst asserted on the edge that would complete a capture -> all outputs at reset values, no update pulse.
REQ-029 SHALL cover: STABLE_CYCLES=1, pattern changing every cycle 0..9 on digitSel=0001 -> BCD[3:0] tracks each value one edge later, update high every cycle.

Source files
------------

// File: rtl/seg7_to_bcd_capture.sv
// Seven-segment display snooper: watches a multiplexed, active-low segment bus and its one-hot
// digit strobe, waits for the pattern to stay put for STABLE_CYCLES edges, then decodes it
// into a BCD code for the strobed digit.
// Optional build macro SEG7_ERR_COUNT_EN adds an 8-bit saturating errCount output.
module seg7_to_bcd_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              n7Segs,
  input  logic [NUM_DIGITS-1:0]   digitSel,
  output logic [4*NUM_DIGITS-1:0] BCD,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    update,
`ifdef SEG7_ERR_COUNT_EN
  output logic [7:0]              errCount,
`endif
  output logic                    errFlag
);

  localparam int unsigned SampleW   = NUM_DIGITS + 7;
  localparam logic [3:0]  StableCnt = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    StEmpty,
    StCount,
    StHeld
  } state_e;

  state_e                  state_q, state_d;
  logic [SampleW-1:0]      sample_q, sample_d;
  logic [3:0]              run_q, run_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    update_q, update_d;
  logic                    err_q, err_d;

  logic [SampleW-1:0] cur_sample;
  logic               same;
  logic               stable_hit;
  logic               sel_onehot;
  logic               capture;
  logic [3:0]         dec_code;
  logic               dec_num;
  logic               dec_blank;
  logic               dec_illegal;

  assign cur_sample = {digitSel, n7Segs};
  assign same       = (cur_sample == sample_q);

  // Digit strobe must name exactly one digit for a capture to be meaningful.
  always_comb begin
    logic [3:0] ones;
    ones = 4'd0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      ones = ones + {3'b000, digitSel[i]};
    end
    sel_onehot = (ones == 4'd1);
  end

  // Active-low pattern {g,f,e,d,c,b,a} to numeral; blank is legal, anything else illegal.
  always_comb begin
    dec_code    = 4'hF;
    dec_num     = 1'b1;
    dec_blank   = 1'b0;
    dec_illegal = 1'b0;
    case (n7Segs)
      7'b1000000: dec_code = 4'd0;
      7'b1111001: dec_code = 4'd1;
      7'b0100100: dec_code = 4'd2;
      7'b0110000: dec_code = 4'd3;
      7'b0011001: dec_code = 4'd4;
      7'b0010010: dec_code = 4'd5;
      7'b0000010: dec_code = 4'd6;
      7'b1111000: dec_code = 4'd7;
      7'b0000000: dec_code = 4'd8;
      7'b0010000: dec_code = 4'd9;
      7'b1111111: begin
        dec_num   = 1'b0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_num     = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Stability tracker: run counts consecutive identical samples, saturating at STABLE_CYCLES.
  always_comb begin
    state_d    = state_q;
    sample_d   = cur_sample;
    run_d      = run_q;
    stable_hit = 1'b0;
    unique case (state_q)
      StEmpty: begin
        run_d = 4'd1;
      end
      StCount: begin
        if (same) begin
          run_d = (run_q < StableCnt) ? run_q + 4'd1 : run_q;
        end else begin
          run_d = 4'd1;
        end
      end
      StHeld: begin
        run_d = same ? run_q : 4'd1;
      end
      default: begin
        run_d = 4'd1;
      end
    endcase
    // A pattern already captured while in StHeld is not captured again.
    if (run_d == StableCnt && !(state_q == StHeld && same)) begin
      stable_hit = 1'b1;
      state_d    = StHeld;
    end else if (state_q == StHeld && same) begin
      state_d = StHeld;
    end else begin
      state_d = StCount;
    end
  end

  // Stability still advances the FSM for a bad strobe, but nothing is written.
  assign capture = stable_hit && sel_onehot;

  // Write the decoded value into the strobed digit only.
  always_comb begin
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    err_d    = err_q;
    update_d = capture;
    if (capture) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (digitSel[i]) begin
          if (dec_num) begin
            bcd_d[4*i +: 4] = dec_code;
            valid_d[i]      = 1'b1;
          end else if (dec_blank) begin
            bcd_d[4*i +: 4] = 4'hF;
            valid_d[i]      = 1'b0;
          end
        end
      end
      if (dec_illegal) begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      sample_q <= '0;
      run_q    <= 4'd0;
      bcd_q    <= '1;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      run_q    <= run_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Count illegal captures, sticking at 255.
  always_comb begin
    errcnt_d = errcnt_q;
    if (capture && dec_illegal && errcnt_q != 8'hFF) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= 8'd0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign errCount = errcnt_q;
`endif

  assign BCD     = bcd_q;
  assign valid   = valid_q;
  assign update  = update_q;
  assign errFlag = err_q;

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// Directed bench: a STABLE_CYCLES=3 instance for the main scenarios and a STABLE_CYCLES=1
// instance for the every-cycle tracking case. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_seg7_to_bcd_capture;

  logic        clk;
  logic        rst;
  logic [6:0]  segs, segs1;
  logic [3:0]  sel, sel1;
  logic [15:0] bcd, bcd1;
  logic [3:0]  vld, vld1;
  logic        upd, upd1;
  logic        err, err1;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0]  ecnt, ecnt1;
`endif

  int unsigned total;
  int unsigned passes;
  logic [6:0]  pat [10];

  seg7_to_bcd_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .n7Segs   (segs),
    .digitSel (sel),
    .BCD      (bcd),
    .valid    (vld),
    .update   (upd),
`ifdef SEG7_ERR_COUNT_EN
    .errCount (ecnt),
`endif
    .errFlag  (err)
  );

  seg7_to_bcd_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .n7Segs   (segs1),
    .digitSel (sel1),
    .BCD      (bcd1),
    .valid    (vld1),
    .update   (upd1),
`ifdef SEG7_ERR_COUNT_EN
    .errCount (ecnt1),
`endif
    .errFlag  (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    passes = 0;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
    pat[8] = 7'b0000000; pat[9] = 7'b0010000;
    rst = 1'b1; sel = 4'b0000; segs = 7'h7F; sel1 = 4'b0000; segs1 = 7'h00;
    tick();
    tick();
    chk("rst_bcd", 32'(bcd), 32'hFFFF);
    chk("rst_valid", 32'(vld), 32'h0);
    chk("rst_update", 32'(upd), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // Digit 0 <= 3 after three identical samples, then silence.
    rst = 1'b0; sel = 4'b0001; segs = 7'b0110000;
    tick();
    chk("d3_e1_update", 32'(upd), 32'h0);
    tick();
    chk("d3_e2_update", 32'(upd), 32'h0);
    chk("d3_e2_bcd", 32'(bcd), 32'hFFFF);
    tick();
    chk("d3_bcd", 32'(bcd), 32'hFFF3);
    chk("d3_valid", 32'(vld), 32'h1);
    chk("d3_update", 32'(upd), 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("d3_hold_update", 32'(upd), 32'h0);
    end
    chk("d3_hold_bcd", 32'(bcd), 32'hFFF3);

    // Digit 1: 5 for two cycles (too short), then 6 for three.
    sel = 4'b0010; segs = 7'b0010010;
    tick();
    tick();
    chk("d6_short_update", 32'(upd), 32'h0);
    segs = 7'b0000010;
    tick();
    tick();
    chk("d6_e2_update", 32'(upd), 32'h0);
    chk("d6_e2_bcd", 32'(bcd), 32'hFFF3);
    tick();
    chk("d6_bcd", 32'(bcd), 32'hFF63);
    chk("d6_valid", 32'(vld), 32'h3);
    chk("d6_update", 32'(upd), 32'h1);
    tick();
    chk("d6_update_end", 32'(upd), 32'h0);

    // Digit 2: illegal pattern sets the sticky flag, digit untouched.
    sel = 4'b0100; segs = 7'b1010101;
    tick();
    tick();
    tick();
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_bcd", 32'(bcd), 32'hFF63);
    chk("ill_valid", 32'(vld), 32'h3);
    chk("ill_update", 32'(upd), 32'h1);
`ifdef SEG7_ERR_COUNT_EN
    chk("ill_errcount", 32'(ecnt), 32'h1);
`endif

    // Two strobes at once: stable but never captured.
    sel = 4'b1100; segs = 7'b1111001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("multi_update", 32'(upd), 32'h0);
    end
    chk("multi_bcd", 32'(bcd), 32'hFF63);
    chk("multi_valid", 32'(vld), 32'h3);

    // Digit 3 <= 4, then blanked.
    sel = 4'b1000; segs = 7'b0011001;
    tick();
    tick();
    tick();
    chk("d4_bcd", 32'(bcd), 32'h4F63);
    chk("d4_valid", 32'(vld), 32'hB);
    segs = 7'b1111111;
    tick();
    tick();
    tick();
    chk("blank_bcd", 32'(bcd), 32'hFF63);
    chk("blank_valid", 32'(vld), 32'h3);
    chk("blank_update", 32'(upd), 32'h1);
    chk("blank_err", 32'(err), 32'h1);

    // Reset lands on the edge that would complete a capture.
    sel = 4'b0001; segs = 7'b0000000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstcap_bcd", 32'(bcd), 32'hFFFF);
    chk("rstcap_valid", 32'(vld), 32'h0);
    chk("rstcap_update", 32'(upd), 32'h0);
    chk("rstcap_err", 32'(err), 32'h0);
`ifdef SEG7_ERR_COUNT_EN
    chk("rstcap_errcount", 32'(ecnt), 32'h0);
`endif
    rst = 1'b0;
    tick();
    chk("fresh_e1_update", 32'(upd), 32'h0);
    tick();
    chk("fresh_e2_update", 32'(upd), 32'h0);
    chk("fresh_e2_bcd", 32'(bcd), 32'hFFFF);
    tick();
    chk("fresh_bcd", 32'(bcd), 32'hFFF8);
    chk("fresh_update", 32'(upd), 32'h1);

    // STABLE_CYCLES=1: a new numeral every cycle is captured every cycle.
    sel1 = 4'b0001;
    for (int v = 0; v < 10; v++) begin
      segs1 = pat[v];
      tick();
      chk("s1_bcd", 32'(bcd1), 32'hFFF0 | 32'(v));
      chk("s1_update", 32'(upd1), 32'h1);
      chk("s1_valid", 32'(vld1), 32'h1);
    end
    tick();
    chk("s1_hold_update", 32'(upd1), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
